// File: rtl/mcca_accumulator_pkg.sv
// Shared definitions for the Manchester carry-chain accumulator: FSM state
// encoding, counter helpers and the adder width legality rule.
package mcca_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The carry chain is built from 4-bit Manchester cells.
    localparam int CELL_W = 4;

    function automatic bit width_ok(input int w);
        return (w >= CELL_W) && ((w % CELL_W) == 0);
    endfunction

endpackage

// File: rtl/MCCAxbit.sv
// Manchester carry-chain adder: 4-bit Manchester cells with a group-propagate
// skip between cells. Purely combinational.
module MCCAxbit
    import mcca_accumulator_pkg::*;
#(
    parameter int size = 16
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic            cin,
    output logic [size-1:0] sum,
    output logic            cout
);

    localparam int NCELL = size / CELL_W;

    logic [size-1:0] gen;
    logic [size-1:0] prop;
    logic [NCELL:0]  cell_c;

    assign gen       = a & b;
    assign prop      = a ^ b;
    assign cell_c[0] = cin;

    for (genvar g = 0; g < NCELL; g++) begin : g_cell
        logic [CELL_W:0] chain;
        logic            cell_p;

        assign chain[0] = cell_c[g];
        for (genvar j = 0; j < CELL_W; j++) begin : g_bit
            assign chain[j+1]          = gen[g*CELL_W+j] | (prop[g*CELL_W+j] & chain[j]);
            assign sum[g*CELL_W+j]     = prop[g*CELL_W+j] ^ chain[j];
        end

        // A fully propagating cell forwards its carry-in without rippling.
        assign cell_p      = &prop[g*CELL_W +: CELL_W];
        assign cell_c[g+1] = cell_p ? cell_c[g] : chain[CELL_W];
    end

    assign cout = cell_c[NCELL];

endmodule

// File: rtl/mcca_accumulator.sv
// Packet accumulator around the Manchester carry-chain adder: sums a stream of
// operands, counts beats and carry-outs, and hands the result off per packet.
module mcca_accumulator
    import mcca_accumulator_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic [COUNT_W-1:0] out_carries,
    output logic [COUNT_W-1:0] out_count
);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("mcca_accumulator: WIDTH must be a multiple of 4 and at least 4");
    end

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [COUNT_W-1:0] carries;
    logic [COUNT_W-1:0] beats;
    logic               ready_q;
    logic               valid_q;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               beat_ok;

    MCCAxbit #(.size(WIDTH)) u_adder (
        .a    (acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // ready_q is only high in IDLE/ACCUM, so this never fires in DONE.
    assign beat_ok = in_valid && ready_q;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            carries <= '0;
            beats   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            acc     <= '0;
            carries <= '0;
            beats   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat_ok) begin
                        acc <= add_sum;
                        if (add_cout && (carries != CNT_MAX)) begin
                            carries <= carries + COUNT_W'(1);
                        end
                        if (beats != CNT_MAX) begin
                            beats <= beats + COUNT_W'(1);
                        end
                        if (in_last) begin
                            state   <= DONE;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                        end else begin
                            state   <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state   <= IDLE;
                        acc     <= '0;
                        carries <= '0;
                        beats   <= '0;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = valid_q;
    assign out_sum     = acc;
    assign out_carries = carries;
    assign out_count   = beats;

endmodule

// File: tb/tb_mcca_accumulator.sv
// Self-checking bench for mcca_accumulator: directed packets plus random
// packets checked against a plain-arithmetic packet model.
module tb_mcca_accumulator;

    localparam int WIDTH   = 16;
    localparam int COUNT_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clear = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   out_sum;
    logic [COUNT_W-1:0] out_carries;
    logic [COUNT_W-1:0] out_count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] pkt[$];

    mcca_accumulator #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_carries (out_carries),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned sum mod 2^WIDTH, count of beats whose running add
    // reached 2^WIDTH, and the beat count, both counts clipped at 2^COUNT_W-1.
    task automatic model(output logic [WIDTH-1:0] es, output logic [COUNT_W-1:0] ec,
                         output logic [COUNT_W-1:0] en);
        longint run = 0;
        int     nc  = 0;
        int     lim = (1 << COUNT_W) - 1;
        foreach (pkt[i]) begin
            run = run + longint'(pkt[i]);
            if (run >= (longint'(1) << WIDTH)) begin
                nc++;
                run = run - (longint'(1) << WIDTH);
            end
        end
        es = WIDTH'(run);
        ec = COUNT_W'((nc > lim) ? lim : nc);
        en = COUNT_W'((pkt.size() > lim) ? lim : pkt.size());
    endtask

    // Streams pkt back-to-back; returns at edge+1 of the edge taking the last beat.
    task automatic send_packet(input string tag);
        foreach (pkt[i]) begin
            int waited = 0;
            in_valid = 1'b1;
            in_data  = pkt[i];
            in_last  = (i == pkt.size() - 1);
            while (!in_ready && waited < 20) begin
                step();
                waited++;
            end
            if (!in_ready) check({tag, " in_ready_timeout"}, 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [WIDTH-1:0] es,
                                 input logic [COUNT_W-1:0] ec, input logic [COUNT_W-1:0] en);
        check({tag, " out_valid"},   32'(out_valid),   32'd1);
        check({tag, " in_ready"},    32'(in_ready),    32'd0);
        check({tag, " out_sum"},     32'(out_sum),     32'(es));
        check({tag, " out_carries"}, 32'(out_carries), 32'(ec));
        check({tag, " out_count"},   32'(out_count),   32'(en));
    endtask

    // Holds the result for `hold` stalled cycles, then completes the hand-off.
    task automatic release_result(input string tag, input int hold, input logic [WIDTH-1:0] es,
                                  input logic [COUNT_W-1:0] ec, input logic [COUNT_W-1:0] en);
        expect_result(tag, es, ec, en);
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            step();
            expect_result({tag, " stall"}, es, ec, en);
        end
        out_ready = 1'b1;
        #1;
        check({tag, " in_ready_on_handoff"}, 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0;
        check({tag, " in_ready_after"},  32'(in_ready),  32'd1);
        check({tag, " out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0]   es;
        logic [COUNT_W-1:0] ec;
        logic [COUNT_W-1:0] en;

        #12;
        check("reset in_ready",    32'(in_ready),    32'd1);
        check("reset out_valid",   32'(out_valid),   32'd0);
        check("reset out_sum",     32'(out_sum),     32'd0);
        check("reset out_carries", 32'(out_carries), 32'd0);
        check("reset out_count",   32'(out_count),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic three-beat packet with the consumer always ready.
        out_ready = 1'b1;
        pkt = '{16'h0001, 16'h0002, 16'h0003};
        send_packet("p123");
        release_result("p123", 0, 16'h0006, 8'd0, 8'd3);

        // Overflow reported through the carry counter.
        pkt = '{16'hFFFF, 16'h0002};
        send_packet("pcarry");
        release_result("pcarry", 0, 16'h0001, 8'd1, 8'd2);

        // Single beat held under back-pressure for five cycles.
        out_ready = 1'b0;
        pkt = '{16'hABCD};
        send_packet("psingle");
        release_result("psingle", 5, 16'hABCD, 8'd0, 8'd1);

        // Counter saturation.
        pkt.delete();
        for (int i = 0; i < 300; i++) pkt.push_back(16'hFFFF);
        send_packet("psat");
        release_result("psat", 0, 16'hFED4, 8'd255, 8'd255);

        // Abort after two beats; the beat presented with clear is dropped.
        pkt = '{16'h1111, 16'h2222};
        send_packet("pabort");
        in_valid = 1'b1;
        in_data  = 16'h3333;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("abort out_valid", 32'(out_valid), 32'd0);
            step();
        end
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_sum",  32'(out_sum),  32'd0);
        pkt = '{16'h0010};
        send_packet("pafter");
        release_result("pafter", 0, 16'h0010, 8'd0, 8'd1);

        // Clear while a result is pending discards it.
        pkt = '{16'h0707};
        send_packet("pdiscard");
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("discard out_valid", 32'(out_valid), 32'd0);
        check("discard in_ready",  32'(in_ready),  32'd1);

        // Random packets with carry-heavy operands and random back-pressure.
        for (int p = 0; p < 12; p++) begin
            int len = $urandom_range(1, 6);
            pkt.delete();
            for (int i = 0; i < len; i++) begin
                logic [WIDTH-1:0] d;
                d = WIDTH'($urandom);
                if ($urandom_range(0, 1) == 1) d[WIDTH-1 -: 4] = 4'hF;
                pkt.push_back(d);
            end
            model(es, ec, en);
            send_packet($sformatf("rand%0d", p));
            release_result($sformatf("rand%0d", p), $urandom_range(0, 3), es, ec, en);
        end

        // Asynchronous reset while a result is held.
        pkt = '{16'h1234};
        send_packet("prst");
        expect_result("prst", 16'h1234, 8'd0, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst out_valid",   32'(out_valid),   32'd0);
        check("async_rst in_ready",    32'(in_ready),    32'd1);
        check("async_rst out_sum",     32'(out_sum),     32'd0);
        check("async_rst out_carries", 32'(out_carries), 32'd0);
        check("async_rst out_count",   32'(out_count),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
